// File: rtl/lsu_bus_master_if.sv
// Request/grant bus between the load/store unit and the data SRAM port.
// The LSU takes the master modport and the memory (or its model) takes the slave modport.
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_o;
  logic              we_o;
  logic [1:0]        hb_o;
  logic              uload_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;
  logic              gnt_i;
  logic [31:0]       rdata_i;

  modport master (
    output req_o, we_o, hb_o, uload_o, addr_o, wdata_o,
    input  gnt_i, rdata_i
  );

  modport slave (
    input  req_o, we_o, hb_o, uload_o, addr_o, wdata_o,
    output gnt_i, rdata_i
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store initiator: checks alignment, issues one request per command, and returns extended load data.
// Define LSU_TIMEOUT_EN to abort a request with bus_err_o after TIMEOUT_CYCLES ungranted WAIT cycles.
module lsu_bus_master #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              we_i,
  input  logic [1:0]        hb_i,
  input  logic              uload_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic [2:0]        state_dbg_o,
  lsu_bus_master_if.master  bus
);

  // Bus handshake: req_o rises the cycle after a command is accepted and holds,
  // with every bus field frozen, until the first cycle gnt_i=1; that cycle
  // completes the transfer and carries rdata_i. gnt_i while req_o=0 is ignored.
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_WAIT = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [1:0]        hb_q, hb_d;
  logic              uload_q, uload_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mis_q, mis_d;
  logic              misalign;
  logic              can_accept;
  logic [31:0]       ext_rdata;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             berr_q, berr_d;
`endif

  assign misalign = (hb_i == 2'b11) |
                    ((hb_i == 2'b10) & (addr_i[1:0] != 2'b00)) |
                    ((hb_i == 2'b01) & addr_i[0]);

  assign can_accept = (state_q == S_IDLE) | (state_q == S_DONE);

  // Extension follows the size latched with the request, not the live command.
  always_comb begin
    ext_rdata = bus.rdata_i;
    case (hb_q)
      2'b00:   ext_rdata = {{24{~uload_q & bus.rdata_i[7]}},  bus.rdata_i[7:0]};
      2'b01:   ext_rdata = {{16{~uload_q & bus.rdata_i[15]}}, bus.rdata_i[15:0]};
      default: ext_rdata = bus.rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    hb_d    = hb_q;
    uload_d = uload_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
    berr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (valid_i) begin
          if (misalign) begin
            mis_d = 1'b1;
          end else begin
            we_d    = we_i;
            hb_d    = hb_i;
            uload_d = uload_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            req_d   = 1'b1;
            state_d = S_WAIT;
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (bus.gnt_i) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) rdata_d = ext_rdata;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      hb_q    <= 2'b10;
      uload_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
      berr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      hb_q    <= hb_d;
      uload_q <= uload_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
`endif
    end
  end

`ifdef LSU_TIMEOUT_EN
  assign bus_err_o = berr_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign bus_err_o      = 1'b0;
`endif

  assign busy_o      = (state_q == S_WAIT) | (can_accept & valid_i & ~misalign);
  assign done_o      = (state_q == S_DONE);
  assign rdata_o     = rdata_q;
  assign misalign_o  = mis_q;
  assign state_dbg_o = state_q;

  assign bus.req_o   = req_q;
  assign bus.we_o    = we_q;
  assign bus.hb_o    = hb_q;
  assign bus.uload_o = uload_q;
  assign bus.addr_o  = addr_q;
  assign bus.wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master: directed test-plan cases plus randomized traffic
// compared every cycle against a transaction-level model of the access rules.
module tb_lsu_bus_master;
  localparam int ADDR_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;

  typedef struct {
    logic        we;
    logic [1:0]  hb;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid_i, we_i, uload_i;
  logic [1:0]  hb_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, done_o, misalign_o, bus_err_o;
  logic [31:0] rdata_o;
  logic [2:0]  state_dbg;

  lsu_bus_master_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_bus_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (valid_i),
    .we_i        (we_i),
    .hb_i        (hb_i),
    .uload_i     (uload_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rdata_o     (rdata_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o),
    .state_dbg_o (state_dbg),
    .bus         (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] extend(input logic [1:0] hb, input logic u, input logic [31:0] d);
    logic [31:0] v;
    case (hb)
      2'd0: begin v = d & 32'h0000_00FF; if (!u && d[7])  v = v | 32'hFFFF_FF00; end
      2'd1: begin v = d & 32'h0000_FFFF; if (!u && d[15]) v = v | 32'hFFFF_0000; end
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic bit is_mis(input logic [1:0] hb, input logic [31:0] a);
    if (hb == 2'd3) return 1'b1;
    return (a % (32'd1 << hb)) != 32'd0;
  endfunction

  logic        m_out, m_done, m_mis, m_berr;
  logic [31:0] m_rdata;
  int          m_wcnt;
  cmd_t        m_cmd;
  logic [31:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out   <= 1'b0;
      m_done  <= 1'b0;
      m_mis   <= 1'b0;
      m_berr  <= 1'b0;
      m_rdata <= 32'd0;
      m_wcnt  <= 0;
      m_cmd   <= '{we: 1'b0, hb: 2'b10, u: 1'b0, addr: 32'd0, wdata: 32'd0};
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      m_mis  <= 1'b0;
      m_berr <= 1'b0;
      if (m_out) begin
        if (bus.gnt_i) begin
          m_out  <= 1'b0;
          m_done <= 1'b1;
          if (!m_cmd.we) begin
            m_rdata <= extend(m_cmd.hb, m_cmd.u, bus.rdata_i);
            exp_q.push_back(extend(m_cmd.hb, m_cmd.u, bus.rdata_i));
          end else begin
            exp_q.push_back(m_rdata);
          end
        end else begin
          m_wcnt <= m_wcnt + 1;
`ifdef LSU_TIMEOUT_EN
          if (m_wcnt + 1 == TIMEOUT_CYCLES) begin
            m_out  <= 1'b0;
            m_berr <= 1'b1;
          end
`endif
        end
      end else if (valid_i) begin
        if (is_mis(hb_i, addr_i)) begin
          m_mis <= 1'b1;
        end else begin
          m_out  <= 1'b1;
          m_wcnt <= 0;
          m_cmd  <= '{we: we_i, hb: hb_i, u: uload_i, addr: addr_i, wdata: wdata_i};
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("req_o",      32'(bus.req_o),   32'(m_out));
      check("we_o",       32'(bus.we_o),    32'(m_cmd.we));
      check("hb_o",       32'(bus.hb_o),    32'(m_cmd.hb));
      check("uload_o",    32'(bus.uload_o), 32'(m_cmd.u));
      check("addr_o",     bus.addr_o,       m_cmd.addr);
      check("wdata_o",    bus.wdata_o,      m_cmd.wdata);
      check("done_o",     32'(done_o),      32'(m_done));
      check("misalign_o", 32'(misalign_o),  32'(m_mis));
      check("bus_err_o",  32'(bus_err_o),   32'(m_berr));
      check("rdata_o",    rdata_o,          m_rdata);
      check("busy_o",     32'(busy_o),
            32'(m_out | (!m_out & valid_i & !is_mis(hb_i, addr_i))));
      check("state_onehot", 32'($onehot(state_dbg)), 32'd1);
      if (done_o && exp_q.size() > 0) check("load_result", rdata_o, exp_q.pop_front());
    end
  end

  // ---------------- memory responder ----------------
  int          fix_lat = 0;
  logic        fix_rd_en = 1'b0;
  logic [31:0] fix_rd = 32'd0;
  logic        no_gnt = 1'b0;

  initial begin
    int rcnt;
    int lat;
    bus.gnt_i   = 1'b0;
    bus.rdata_i = 32'd0;
    rcnt = 0;
    lat  = 1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus.gnt_i = 1'b0;
        rcnt = 0;
      end else if (bus.req_o) begin
        if (rcnt == 0) lat = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 4));
        rcnt++;
        bus.gnt_i = !no_gnt && (rcnt == lat);
      end else begin
        rcnt = 0;
        bus.gnt_i = !no_gnt && ($urandom_range(0, 3) == 0);
      end
      bus.rdata_i = fix_rd_en ? fix_rd : $urandom;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [1:0] hb, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_i = 1'b1;
    we_i    = we;
    hb_i    = hb;
    uload_i = u;
    addr_i  = a;
    wdata_i = wd;
  endtask

  // Returns one time unit after the edge that raises done_o, or after a 40-cycle budget.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      if (cyc == 0) valid_i = 1'b0;
      cyc++;
    end while (!done_o && cyc < 40);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          n;
    int          ndone;
    logic [1:0]  mis_hb [3];
    logic [31:0] mis_ad [3];
    logic [31:0] ra;

    mis_hb[0] = 2'b10; mis_ad[0] = 32'h0000_0101;
    mis_hb[1] = 2'b01; mis_ad[1] = 32'h0000_0203;
    mis_hb[2] = 2'b11; mis_ad[2] = 32'h0000_0300;

    valid_i = 1'b0; we_i = 1'b0; hb_i = 2'b10; uload_i = 1'b0;
    addr_i = 32'd0; wdata_i = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   32'(bus.req_o),   32'd0);
    check("rst_we",    32'(bus.we_o),    32'd0);
    check("rst_hb",    32'(bus.hb_o),    32'd2);
    check("rst_uload", 32'(bus.uload_o), 32'd0);
    check("rst_addr",  bus.addr_o,       32'd0);
    check("rst_wdata", bus.wdata_o,      32'd0);
    check("rst_rdata", rdata_o,          32'd0);
    check("rst_done",  32'(done_o),      32'd0);
    check("rst_mis",   32'(misalign_o),  32'd0);
    check("rst_berr",  32'(bus_err_o),   32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;

    // word load, grant on the third request cycle
    fix_lat = 3; fix_rd_en = 1'b1; fix_rd = 32'hCACA_CACA;
    drive(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0);
    @(negedge clk);
    check("t1_busy_cmd", 32'(busy_o), 32'd1);
    wait_done(cyc);
    check("t1_latency", 32'(cyc), 32'd4);
    check("t1_rdata",   rdata_o, 32'hCACA_CACA);
    check("t1_req_low", 32'(bus.req_o), 32'd0);
    idle(2);

    // byte/half extension
    fix_lat = 0; fix_rd = 32'h0000_0080;
    drive(1'b0, 2'b00, 1'b0, 32'h0000_0023, 32'd0);
    wait_done(cyc);
    check("sbyte", rdata_o, 32'hFFFF_FF80);
    idle(1);
    drive(1'b0, 2'b00, 1'b1, 32'h0000_0022, 32'd0);
    wait_done(cyc);
    check("ubyte", rdata_o, 32'h0000_0080);
    idle(1);
    fix_rd = 32'h0000_8001;
    drive(1'b0, 2'b01, 1'b0, 32'h0000_0046, 32'd0);
    wait_done(cyc);
    check("shalf", rdata_o, 32'hFFFF_8001);
    idle(1);

    // half store
    fix_lat = 3;
    drive(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_1234);
    @(negedge clk);
    @(negedge clk);
    check("st_req",   32'(bus.req_o), 32'd1);
    check("st_we",    32'(bus.we_o),  32'd1);
    check("st_hb",    32'(bus.hb_o),  32'd1);
    check("st_addr",  bus.addr_o,     32'h0000_0102);
    check("st_wdata", bus.wdata_o,    32'h0000_1234);
    wait_done(cyc);
    check("st_done",  32'(done_o), 32'd1);
    check("st_rdata_kept", rdata_o, 32'hFFFF_8001);
    idle(2);

    // rejected commands
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, mis_hb[i], 1'b0, mis_ad[i], 32'd0);
      @(negedge clk);
      check("mis_busy", 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      check("mis_pulse", 32'(misalign_o), 32'd1);
      check("mis_noreq", 32'(bus.req_o), 32'd0);
      @(posedge clk);
      #1;
      check("mis_single", 32'(misalign_o), 32'd0);
      check("mis_noreq2", 32'(bus.req_o), 32'd0);
    end

    // back-to-back: second command presented in the DONE cycle
    fix_lat = 2; fix_rd = 32'h1111_2222;
    drive(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'd0);
    wait_done(cyc);
    check("b2b_done1", 32'(done_o), 32'd1);
    drive(1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'd0);
    @(negedge clk);
    check("b2b_busy", 32'(busy_o), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_req",  32'(bus.req_o), 32'd1);
    check("b2b_addr", bus.addr_o, 32'h0000_0304);
    wait_done(cyc);
    check("b2b_done2", 32'(done_o), 32'd1);
    idle(2);

    // reset while waiting for grant
    fix_lat = 3;
    drive(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("rw_req_before", 32'(bus.req_o), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("rw_req_async", 32'(bus.req_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      ndone += int'(done_o);
    end
    check("rw_no_done", 32'(ndone), 32'd0);

`ifdef LSU_TIMEOUT_EN
    no_gnt = 1'b1;
    drive(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'd0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    n = 0;
    while (bus.req_o && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("to_wait_cycles", 32'(n), 32'd16);
    check("to_berr", 32'(bus_err_o), 32'd1);
    check("to_req",  32'(bus.req_o), 32'd0);
    check("to_nodone", 32'(done_o), 32'd0);
    no_gnt = 1'b0;
    idle(2);
`else
    n = 0;
`endif

    // randomized traffic
    fix_lat = 0; fix_rd_en = 1'b0;
    repeat (500) begin
      valid_i = ($urandom_range(0, 9) < 6);
      we_i    = $urandom_range(0, 1);
      hb_i    = $urandom_range(0, 3);
      uload_i = $urandom_range(0, 1);
      ra      = $urandom;
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      addr_i  = ra;
      wdata_i = $urandom;
      @(posedge clk);
      #1;
    end
    idle(8);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
